alu_rs_scheduler: RTL and testbench

- ALU reservation station with wakeup/select logic.
- Sits between dispatch and the integer ALU, and stores ops whose source operands come from the source-operand manager stage. Each operand is either data (ready) or an RRF tag in bits [RRF_SEL-1:0] (not ready).
- Snoops the result broadcast to replace tags with data, selects one fully ready entry per cycle, and issues it through a registered issue stage.

---
 rtl/alu_rs_scheduler.sv | 153 +++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: integer ALU reservation station. Holds dispatched ops
// until both operands carry data (snooping the result broadcast for tags),
// then issues the lowest-index ready entry through a registered issue stage.
module alu_rs_scheduler #(
    parameter int ENTRY_NUM = 4,
    parameter int DATA_LEN  = 32,
    parameter int RRF_SEL   = 6,
    parameter int PAYLOAD_W = 16,
    localparam int CNT_W    = $clog2(ENTRY_NUM) + 1,
    localparam int IDX_W    = $clog2(ENTRY_NUM)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 kill_i,
    input  logic                 dp_we_i,
    input  logic [DATA_LEN-1:0]  dp_src1_i,
    input  logic                 dp_rdy1_i,
    input  logic [DATA_LEN-1:0]  dp_src2_i,
    input  logic                 dp_rdy2_i,
    input  logic [RRF_SEL-1:0]   dp_rrftag_i,
    input  logic [PAYLOAD_W-1:0] dp_payload_i,
    input  logic                 wb_valid_i,
    input  logic [RRF_SEL-1:0]   wb_rrftag_i,
    input  logic [DATA_LEN-1:0]  wb_data_i,
    input  logic                 exe_ready_i,
    output logic                 rs_full_o,
    output logic [CNT_W-1:0]     rs_cnt_o,
    output logic                 issue_valid_o,
    output logic [DATA_LEN-1:0]  issue_src1_o,
    output logic [DATA_LEN-1:0]  issue_src2_o,
    output logic [RRF_SEL-1:0]   issue_rrftag_o,
    output logic [PAYLOAD_W-1:0] issue_payload_o
);

    logic [ENTRY_NUM-1:0] valid_q, rdy1_q, rdy2_q;
    logic [DATA_LEN-1:0]  src1_q    [ENTRY_NUM];
    logic [DATA_LEN-1:0]  src2_q    [ENTRY_NUM];
    logic [RRF_SEL-1:0]   rrftag_q  [ENTRY_NUM];
    logic [PAYLOAD_W-1:0] payload_q [ENTRY_NUM];

    logic [IDX_W-1:0] alloc_idx, sel_idx;
    logic             free_found, sel_found;
    logic             alloc, issue_fire;
    logic             dp_hit1, dp_hit2;
    logic [CNT_W-1:0] cnt_nxt;

    // Lowest free entry and lowest fully-ready entry, both from registered state.
    always_comb begin
        alloc_idx  = '0;
        free_found = 1'b0;
        sel_idx    = '0;
        sel_found  = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx  = IDX_W'(i);
                free_found = 1'b1;
            end
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign alloc      = dp_we_i && !rs_full_o && free_found;
    assign issue_fire = exe_ready_i && sel_found;
    // A dispatched operand whose tag is on the broadcast this cycle would
    // otherwise miss its wakeup, so capture the data directly.
    assign dp_hit1    = !dp_rdy1_i && wb_valid_i && (dp_src1_i[RRF_SEL-1:0] == wb_rrftag_i);
    assign dp_hit2    = !dp_rdy2_i && wb_valid_i && (dp_src2_i[RRF_SEL-1:0] == wb_rrftag_i);
    assign cnt_nxt    = rs_cnt_o + CNT_W'(alloc) - CNT_W'(issue_fire);

    // Entry storage: wakeup, issue-clear and allocation.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
                rrftag_q[i]  <= '0;
                payload_q[i] <= '0;
            end
        end else if (kill_i) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (valid_q[i] && !rdy1_q[i] && wb_valid_i &&
                    src1_q[i][RRF_SEL-1:0] == wb_rrftag_i) begin
                    src1_q[i] <= wb_data_i;
                    rdy1_q[i] <= 1'b1;
                end
                if (valid_q[i] && !rdy2_q[i] && wb_valid_i &&
                    src2_q[i][RRF_SEL-1:0] == wb_rrftag_i) begin
                    src2_q[i] <= wb_data_i;
                    rdy2_q[i] <= 1'b1;
                end
            end
            // The issued entry is valid and the allocated one is not, so they never collide.
            if (issue_fire) begin
                valid_q[sel_idx] <= 1'b0;
            end
            if (alloc) begin
                valid_q[alloc_idx]   <= 1'b1;
                rdy1_q[alloc_idx]    <= dp_rdy1_i || dp_hit1;
                rdy2_q[alloc_idx]    <= dp_rdy2_i || dp_hit2;
                src1_q[alloc_idx]    <= dp_hit1 ? wb_data_i : dp_src1_i;
                src2_q[alloc_idx]    <= dp_hit2 ? wb_data_i : dp_src2_i;
                rrftag_q[alloc_idx]  <= dp_rrftag_i;
                payload_q[alloc_idx] <= dp_payload_i;
            end
        end
    end

    // Occupancy count and registered full flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rs_cnt_o  <= '0;
            rs_full_o <= 1'b0;
        end else if (kill_i) begin
            rs_cnt_o  <= '0;
            rs_full_o <= 1'b0;
        end else begin
            rs_cnt_o  <= cnt_nxt;
            rs_full_o <= (cnt_nxt == CNT_W'(ENTRY_NUM));
        end
    end

    // Issue stage: one-cycle valid pulse per op; data holds between issues.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issue_valid_o   <= 1'b0;
            issue_src1_o    <= '0;
            issue_src2_o    <= '0;
            issue_rrftag_o  <= '0;
            issue_payload_o <= '0;
        end else if (kill_i) begin
            issue_valid_o <= 1'b0;
        end else begin
            issue_valid_o <= issue_fire;
            if (issue_fire) begin
                issue_src1_o    <= src1_q[sel_idx];
                issue_src2_o    <= src2_q[sel_idx];
                issue_rrftag_o  <= rrftag_q[sel_idx];
                issue_payload_o <= payload_q[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: directed scenarios followed by random traffic, checked
// against a behavioural model of the reservation station with a scoreboard.
module tb_alu_rs_scheduler;
    localparam int N  = 4;
    localparam int DL = 32;
    localparam int RS = 6;
    localparam int PW = 16;
    localparam int CW = $clog2(N) + 1;

    logic          clk_i, reset_n_i, kill_i, dp_we_i, dp_rdy1_i, dp_rdy2_i;
    logic          wb_valid_i, exe_ready_i;
    logic [DL-1:0] dp_src1_i, dp_src2_i, wb_data_i;
    logic [RS-1:0] dp_rrftag_i, wb_rrftag_i;
    logic [PW-1:0] dp_payload_i;
    logic          rs_full_o, issue_valid_o;
    logic [CW-1:0] rs_cnt_o;
    logic [DL-1:0] issue_src1_o, issue_src2_o;
    logic [RS-1:0] issue_rrftag_o;
    logic [PW-1:0] issue_payload_o;

    alu_rs_scheduler #(.ENTRY_NUM(N), .DATA_LEN(DL), .RRF_SEL(RS), .PAYLOAD_W(PW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .kill_i(kill_i),
        .dp_we_i(dp_we_i), .dp_src1_i(dp_src1_i), .dp_rdy1_i(dp_rdy1_i),
        .dp_src2_i(dp_src2_i), .dp_rdy2_i(dp_rdy2_i), .dp_rrftag_i(dp_rrftag_i),
        .dp_payload_i(dp_payload_i), .wb_valid_i(wb_valid_i), .wb_rrftag_i(wb_rrftag_i),
        .wb_data_i(wb_data_i), .exe_ready_i(exe_ready_i), .rs_full_o(rs_full_o),
        .rs_cnt_o(rs_cnt_o), .issue_valid_o(issue_valid_o), .issue_src1_o(issue_src1_o),
        .issue_src2_o(issue_src2_o), .issue_rrftag_o(issue_rrftag_o),
        .issue_payload_o(issue_payload_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        bit            v, r1, r2;
        logic [DL-1:0] s1, s2;
        logic [RS-1:0] tag;
        logic [PW-1:0] pl;
    } ent_t;

    typedef struct {
        logic [DL-1:0] s1, s2;
        logic [RS-1:0] tag;
        logic [PW-1:0] pl;
    } iss_t;

    ent_t m_ent [N];
    iss_t exp_q [$];
    iss_t m_last;
    bit   m_iv;
    int   checks = 0;
    int   errors = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < N; i++) if (m_ent[i].v) n++;
        return n;
    endfunction

    function automatic bit wb_hits(input logic [DL-1:0] src);
        return wb_valid_i && (src[RS-1:0] == wb_rrftag_i);
    endfunction

    // One clock of reservation-station behaviour, written from the rules:
    // oldest-ready-by-slot issues, lowest free slot allocates, tags wake up.
    function automatic void model_step();
        ent_t nxt [N];
        int   sel = -1;
        int   fr  = -1;
        bit   full;
        iss_t e;
        full = (m_count() == N);
        for (int i = 0; i < N; i++) begin
            if (sel < 0 && m_ent[i].v && m_ent[i].r1 && m_ent[i].r2) sel = i;
            if (fr < 0 && !m_ent[i].v) fr = i;
        end
        nxt = m_ent;
        for (int i = 0; i < N; i++) begin
            if (m_ent[i].v && !m_ent[i].r1 && wb_hits(m_ent[i].s1)) begin
                nxt[i].s1 = wb_data_i; nxt[i].r1 = 1'b1;
            end
            if (m_ent[i].v && !m_ent[i].r2 && wb_hits(m_ent[i].s2)) begin
                nxt[i].s2 = wb_data_i; nxt[i].r2 = 1'b1;
            end
        end
        m_iv = 1'b0;
        if (exe_ready_i && sel >= 0) begin
            e.s1 = m_ent[sel].s1; e.s2 = m_ent[sel].s2;
            e.tag = m_ent[sel].tag; e.pl = m_ent[sel].pl;
            exp_q.push_back(e);
            m_last = e;
            m_iv = 1'b1;
            nxt[sel].v = 1'b0;
        end
        if (dp_we_i && !full) begin
            nxt[fr].v   = 1'b1;
            nxt[fr].tag = dp_rrftag_i;
            nxt[fr].pl  = dp_payload_i;
            if (!dp_rdy1_i && wb_hits(dp_src1_i)) begin
                nxt[fr].s1 = wb_data_i; nxt[fr].r1 = 1'b1;
            end else begin
                nxt[fr].s1 = dp_src1_i; nxt[fr].r1 = dp_rdy1_i;
            end
            if (!dp_rdy2_i && wb_hits(dp_src2_i)) begin
                nxt[fr].s2 = wb_data_i; nxt[fr].r2 = 1'b1;
            end else begin
                nxt[fr].s2 = dp_src2_i; nxt[fr].r2 = dp_rdy2_i;
            end
        end
        m_ent = nxt;
    endfunction

    // Reference model advances on the same edges as the DUT.
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < N; i++) m_ent[i] = '{default: 0};
            m_last = '{default: 0};
            m_iv   = 1'b0;
            exp_q.delete();
        end else if (kill_i) begin
            for (int i = 0; i < N; i++) m_ent[i].v = 1'b0;
            m_iv = 1'b0;
        end else begin
            model_step();
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on each issue.
    always @(negedge clk_i) begin : monitor
        iss_t e;
        if (reset_n_i) begin
            checks++;
            if (rs_cnt_o != CW'(m_count())) begin
                errors++;
                $display("FAIL rs_cnt: got %0d required %0d at %0t", rs_cnt_o, m_count(), $time);
            end
            checks++;
            if (rs_full_o !== (m_count() == N)) begin
                errors++;
                $display("FAIL rs_full: got %b required %b at %0t", rs_full_o, m_count() == N, $time);
            end
            checks++;
            if (issue_valid_o !== m_iv) begin
                errors++;
                $display("FAIL issue_valid: got %b required %b at %0t", issue_valid_o, m_iv, $time);
            end
            if (issue_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_extra: got payload %h required no issue at %0t", issue_payload_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({issue_src1_o, issue_src2_o, issue_rrftag_o, issue_payload_o} !==
                        {e.s1, e.s2, e.tag, e.pl}) begin
                        errors++;
                        $display("FAIL issue_data: got %h/%h/%h/%h required %h/%h/%h/%h at %0t",
                                 issue_src1_o, issue_src2_o, issue_rrftag_o, issue_payload_o,
                                 e.s1, e.s2, e.tag, e.pl, $time);
                    end
                end
            end else begin
                checks++;
                if ({issue_src1_o, issue_src2_o, issue_rrftag_o, issue_payload_o} !==
                    {m_last.s1, m_last.s2, m_last.tag, m_last.pl}) begin
                    errors++;
                    $display("FAIL issue_hold: got %h/%h/%h/%h required %h/%h/%h/%h at %0t",
                             issue_src1_o, issue_src2_o, issue_rrftag_o, issue_payload_o,
                             m_last.s1, m_last.s2, m_last.tag, m_last.pl, $time);
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        checks++;
        if (rs_cnt_o !== '0 || rs_full_o !== 1'b0 || issue_valid_o !== 1'b0 ||
            issue_src1_o !== '0 || issue_src2_o !== '0 || issue_rrftag_o !== '0 ||
            issue_payload_o !== '0) begin
            errors++;
            $display("FAIL %s: got cnt=%0d full=%b iv=%b data=%h/%h/%h/%h required all zero",
                     nm, rs_cnt_o, rs_full_o, issue_valid_o, issue_src1_o, issue_src2_o,
                     issue_rrftag_o, issue_payload_o);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic disp(input logic [DL-1:0] s1, input bit r1, input logic [DL-1:0] s2,
                        input bit r2, input logic [RS-1:0] tag, input logic [PW-1:0] pl);
        dp_we_i = 1'b1; dp_src1_i = s1; dp_rdy1_i = r1; dp_src2_i = s2; dp_rdy2_i = r2;
        dp_rrftag_i = tag; dp_payload_i = pl;
    endtask

    task automatic bcast(input bit v, input logic [RS-1:0] tag, input logic [DL-1:0] d);
        wb_valid_i = v; wb_rrftag_i = tag; wb_data_i = d;
    endtask

    initial begin
        logic [DL-1:0] tmp;
        reset_n_i = 1'b0; kill_i = 1'b0; exe_ready_i = 1'b0;
        dp_we_i = 1'b0; dp_src1_i = '0; dp_rdy1_i = 1'b0; dp_src2_i = '0; dp_rdy2_i = 1'b0;
        dp_rrftag_i = '0; dp_payload_i = '0;
        bcast(1'b0, '0, '0);
        repeat (2) step();
        chk_zero("reset_state");
        reset_n_i = 1'b1;
        step();

        // Ready dispatch: issues two cycles later, count returns to 0.
        exe_ready_i = 1'b1;
        disp(32'h10, 1'b1, 32'h20, 1'b1, 6'd5, 16'h0001);
        step(); dp_we_i = 1'b0;
        repeat (4) step();

        // Wakeup; non-matching broadcast in the idle window; upper tag bits junk.
        disp(32'hFFFF_FF07, 1'b0, 32'h3, 1'b1, 6'd2, 16'h0002);
        step(); dp_we_i = 1'b0;
        step(); bcast(1'b1, 6'd8, 32'h1234);
        step(); bcast(1'b0, '0, '0);
        step(); bcast(1'b1, 6'd7, 32'hABCD);
        step(); bcast(1'b0, '0, '0);
        repeat (3) step();

        // Dispatch bypass.
        disp(32'h1, 1'b1, 32'h9, 1'b0, 6'd3, 16'h0003);
        bcast(1'b1, 6'd9, 32'h55);
        step(); dp_we_i = 1'b0; bcast(1'b0, '0, '0);
        repeat (4) step();

        // Full and priority, 5th dispatch ignored.
        exe_ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            disp(DL'(k * 16'h100), 1'b1, DL'(k), 1'b1, RS'(k), PW'(k));
            step();
        end
        dp_we_i = 1'b0; step();
        exe_ready_i = 1'b1;
        repeat (6) step();

        // Simultaneous issue and dispatch while full.
        exe_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(DL'(k + 32'h40), 1'b1, DL'(k + 32'h80), 1'b1, RS'(k + 10), PW'(k + 16'h11));
            step();
        end
        dp_we_i = 1'b0; step();
        exe_ready_i = 1'b1; disp(32'hD1, 1'b1, 32'hD2, 1'b1, 6'd20, 16'h0015);
        step(); exe_ready_i = 1'b0; disp(32'hE1, 1'b1, 32'hE2, 1'b1, 6'd21, 16'h0016);
        step(); dp_we_i = 1'b0;
        repeat (2) step();
        exe_ready_i = 1'b1;
        repeat (6) step();

        // Kill with 3 valid entries, an op in the issue stage and a dispatch.
        exe_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(DL'(k + 1), 1'b1, DL'(k + 2), 1'b1, RS'(k + 30), PW'(k + 16'h21));
            step();
        end
        dp_we_i = 1'b0;
        exe_ready_i = 1'b1; step();
        kill_i = 1'b1; disp(32'h77, 1'b1, 32'h78, 1'b1, 6'd40, 16'h0031);
        step(); kill_i = 1'b0; dp_we_i = 1'b0;
        repeat (3) step();

        // Asynchronous reset mid-stream.
        exe_ready_i = 1'b0;
        disp(32'h5, 1'b0, 32'h6, 1'b1, 6'd41, 16'h0041);
        step(); dp_we_i = 1'b0;
        @(posedge clk_i); #2;
        reset_n_i = 1'b0;
        #1;
        chk_zero("async_reset");
        step(); reset_n_i = 1'b1;
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            dp_we_i      = ($urandom_range(0, 99) < 60);
            dp_rdy1_i    = 1'($urandom_range(0, 1));
            dp_rdy2_i    = 1'($urandom_range(0, 1));
            tmp          = $urandom;
            dp_src1_i    = dp_rdy1_i ? tmp : {tmp[DL-1:RS], RS'($urandom_range(0, 7))};
            tmp          = $urandom;
            dp_src2_i    = dp_rdy2_i ? tmp : {tmp[DL-1:RS], RS'($urandom_range(0, 7))};
            dp_rrftag_i  = RS'($urandom_range(0, 63));
            dp_payload_i = PW'($urandom);
            bcast(($urandom_range(0, 99) < 50), RS'($urandom_range(0, 9)), $urandom);
            exe_ready_i  = ($urandom_range(0, 99) < 70);
            kill_i       = ($urandom_range(0, 99) < 2);
            step();
        end

        // Drain: wake every tag in use and let everything issue.
        dp_we_i = 1'b0; kill_i = 1'b0; exe_ready_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bcast(1'b1, RS'(c % 8), $urandom);
            step();
        end
        bcast(1'b0, '0, '0);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
